stack_rpn_ctrl: RTL
===================

Name: stack_rpn_ctrl

Overview:
Command sequencer that sits directly upstream of the 8-bit, 15-entry LIFO stack and drives its push/pop/data_in ports. It accepts reverse-Polish commands over a valid/ready handshake and turns each one into a timed series of single-cycle stack strobes. It captures popped operands from the stack's registered data_out, computes arithmetic results and pushes them back. A shadow depth counter rejects overflow and underflow before any strobe is issued.

Parameters:
DEPTH, 15, usable stack entries; must match the stack's capacity.
POP_LATENCY, 2, cycles from the stack_pop cycle to the cycle in which stack_rdata holds the popped value.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 XOR, 111 DUP
cmd_data  in  8  immediate operand for PUSH
stack_push  out  1  to stack push
stack_pop  out  1  to stack pop
stack_wdata  out  8  to stack data_in
stack_rdata  in  8  from stack data_out
stack_error  in  1  from stack error
result_valid  out  1  one-cycle result strobe
result_data  out  8  result value
depth  out  4  shadow entry count, 0..DEPTH
err  out  1  sticky error flag
err_code  out  2  first error: 1 overflow, 2 underflow, 3 stack-reported error

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1; FSM = IDLE.
- Reset asserted mid-command aborts immediately. The stack is reset separately by the system.
- Accept on cmd_valid && cmd_ready in cycle T; all timing below is relative to T.
- stack_push and stack_pop are one-cycle pulses and are never high in the same cycle.
- stack_wdata is valid in every cycle in which stack_push = 1 and is 0 otherwise.
- FSM states: IDLE, PUSH, POP_A, WAIT_A, POP_B, WAIT_B, PUSH_R, DUP2, RESP.
- NOP: no strobes; stays in IDLE; cmd_ready remains 1.
- PUSH:
  - stack_push = 1 with stack_wdata = cmd_data in T+1.
  - depth increments at the end of T+1.
  - IDLE in T+2.
- POP:
  - stack_pop in T+1.
  - WAIT_A counts POP_LATENCY-1 cycles.
  - stack_rdata is captured as A at the end of T+1+POP_LATENCY.
  - RESP: result_valid = 1, result_data = A in T+2+POP_LATENCY.
  - IDLE next cycle.
- ADD/SUB/AND/XOR:
  - Pop A (top), wait, then pop B with stack_pop in T+2+POP_LATENCY and the same wait.
  - PUSH_R pushes R in T+3+2*POP_LATENCY.
  - ADD: R = B+A mod 256. SUB: R = B-A mod 256. AND: R = B&A. XOR: R = B^A.
  - Net depth change: -1.
- DUP:
  - Pop A, then PUSH_R pushes A, then DUP2 pushes A.
  - Net depth change: +1.
- Pre-checks in IDLE at acceptance. On failure: command consumed, no strobes, err set, FSM stays in IDLE.
  - PUSH with depth == DEPTH: overflow.
  - POP with depth == 0: underflow.
  - Binary op with depth < 2: underflow.
  - DUP with depth == 0: underflow.
  - DUP with depth == DEPTH: overflow.
- err_code latches only the first error. err and err_code clear only on reset.
- stack_error sampled high in any cycle sets code 3 if err == 0; it does not stop the FSM.
- Width rules: depth saturates by construction and never wraps; all arithmetic is 8-bit with carry/borrow discarded.

Optional Feature:
Macro RPN_RESULT_ECHO_EN.
- Defined: ADD/SUB/AND/XOR/DUP also pulse result_valid with result_data = the pushed value R in the first PUSH_R cycle.
- Undefined: only POP produces result_valid; result_data holds its last value otherwise.

Test Plan:
1. Reset low 3 cycles, release; PUSH 0x12 -> stack_push = 1, stack_wdata = 0x12 in T+1; depth = 1; cmd_ready back in T+2.
2. PUSH 0x05, PUSH 0x03, SUB, POP -> result_data = 0x02 with result_valid in T+4 of the POP; depth = 0.
3. PUSH 0xF0, PUSH 0x20, ADD, POP -> result 0x10 (wrap). With RPN_RESULT_ECHO_EN, an extra result_valid = 0x10 during the ADD.
4. 15 PUSHes then a 16th PUSH -> no strobe, err = 1, err_code = 1, depth = 15; a following POP still returns the last pushed value.
5. From reset, ADD with depth = 1 (after one PUSH) -> no strobes, err_code = 2, depth unchanged.
6. PUSH 0xA5, DUP, POP, POP -> two results of 0xA5; reset asserted mid-DUP -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/stack_rpn_ctrl.sv
// stack_rpn_ctrl: reverse-Polish command sequencer driving an external LIFO.
// Each accepted command becomes a timed series of single-cycle push/pop
// strobes. A shadow depth counter rejects overflow and underflow up front.
// Optional build macro: RPN_RESULT_ECHO_EN (echo pushed results on result_*).
module stack_rpn_ctrl #(
  parameter int DEPTH       = 15,
  parameter int POP_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       stack_push,
  output logic       stack_pop,
  output logic [7:0] stack_wdata,
  input  logic [7:0] stack_rdata,
  input  logic       stack_error,
  output logic       result_valid,
  output logic [7:0] result_data,
  output logic [3:0] depth,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int         CW      = (POP_LATENCY > 1) ? $clog2(POP_LATENCY) : 1;
  localparam logic [CW-1:0] WLAST = CW'(POP_LATENCY - 1);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_POP_A, S_WAIT_A, S_POP_B, S_WAIT_B, S_PUSH_R, S_DUP2, S_RESP
  } state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_op;
  logic [7:0]      r_data;
  logic [7:0]      r_a;
  logic [7:0]      r_r;
  logic [7:0]      r_result;
  logic [3:0]      r_depth;
  logic            r_err;
  logic [1:0]      r_code;
  logic [CW-1:0]   r_wcnt;
  logic            w_pre_err;
  logic [1:0]      w_pre_code;
  logic            w_wlast;

  // 8-bit result of a binary op; b is the deeper operand, a the former top
  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] b,
                                     input logic [7:0] a);
    case (op)
      OP_ADD:  alu = b + a;
      OP_SUB:  alu = b - a;
      OP_AND:  alu = b & a;
      OP_XOR:  alu = b ^ a;
      default: alu = a;
    endcase
  endfunction

  assign w_wlast     = (r_wcnt == WLAST);
  assign result_data = r_result;
  assign depth       = r_depth;
  assign err         = r_err;
  assign err_code    = r_code;

  // Next-state, strobes and acceptance pre-checks
  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    stack_push   = 1'b0;
    stack_pop    = 1'b0;
    stack_wdata  = 8'h00;
    result_valid = 1'b0;
    w_pre_err    = 1'b0;
    w_pre_code   = 2'd0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (r_depth == DEPTH_C) begin
                w_pre_err = 1'b1; w_pre_code = 2'd1;
              end else w_next = S_PUSH;
            end
            OP_POP: begin
              if (r_depth == 4'd0) begin
                w_pre_err = 1'b1; w_pre_code = 2'd2;
              end else w_next = S_POP_A;
            end
            OP_DUP: begin
              if (r_depth == 4'd0) begin
                w_pre_err = 1'b1; w_pre_code = 2'd2;
              end else if (r_depth == DEPTH_C) begin
                w_pre_err = 1'b1; w_pre_code = 2'd1;
              end else w_next = S_POP_A;
            end
            default: begin
              if (r_depth < 4'd2) begin
                w_pre_err = 1'b1; w_pre_code = 2'd2;
              end else w_next = S_POP_A;
            end
          endcase
        end
      end
      S_PUSH: begin
        stack_push  = 1'b1;
        stack_wdata = r_data;
        w_next      = S_IDLE;
      end
      S_POP_A: begin
        stack_pop = 1'b1;
        w_next    = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (w_wlast) begin
          if (r_op == OP_POP)      w_next = S_RESP;
          else if (r_op == OP_DUP) w_next = S_PUSH_R;
          else                     w_next = S_POP_B;
        end
      end
      S_POP_B: begin
        stack_pop = 1'b1;
        w_next    = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (w_wlast) w_next = S_PUSH_R;
      end
      S_PUSH_R: begin
        stack_push  = 1'b1;
        stack_wdata = r_r;
`ifdef RPN_RESULT_ECHO_EN
        result_valid = 1'b1;
`endif
        w_next = (r_op == OP_DUP) ? S_DUP2 : S_IDLE;
      end
      S_DUP2: begin
        stack_push  = 1'b1;
        stack_wdata = r_r;
        w_next      = S_IDLE;
      end
      S_RESP: begin
        result_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Command capture, wait counter and operand/result datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_NOP;
      r_data   <= 8'h00;
      r_a      <= 8'h00;
      r_r      <= 8'h00;
      r_result <= 8'h00;
      r_wcnt   <= '0;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
      end
      if ((r_state == S_WAIT_A || r_state == S_WAIT_B) && !w_wlast)
        r_wcnt <= r_wcnt + 1'b1;
      else
        r_wcnt <= '0;
      if (r_state == S_WAIT_A && w_wlast) begin
        r_a <= stack_rdata;
        if (r_op == OP_POP) r_result <= stack_rdata;
        if (r_op == OP_DUP) begin
          r_r <= stack_rdata;
`ifdef RPN_RESULT_ECHO_EN
          r_result <= stack_rdata;
`endif
        end
      end
      if (r_state == S_WAIT_B && w_wlast) begin
        r_r <= alu(r_op, stack_rdata, r_a);
`ifdef RPN_RESULT_ECHO_EN
        r_result <= alu(r_op, stack_rdata, r_a);
`endif
      end
    end
  end

  // Shadow depth follows the strobes; push and pop are never simultaneous
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_depth <= 4'd0;
    else if (stack_push) r_depth <= r_depth + 4'd1;
    else if (stack_pop)  r_depth <= r_depth - 4'd1;
  end

  // Sticky error flag; only the first error's code is kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err  <= 1'b0;
      r_code <= 2'd0;
    end else if (!r_err) begin
      if (w_pre_err) begin
        r_err  <= 1'b1;
        r_code <= w_pre_code;
      end else if (stack_error) begin
        r_err  <= 1'b1;
        r_code <= 2'd3;
      end
    end
  end

endmodule
